cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/arb_sat_cnt.sv | 19 +
 rtl/cache_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: word type, RAM handshake states and arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DSERV = 2'b01,
    ISERV = 2'b10
  } arb_state_t;

  localparam int unsigned GRANT_CNT_W = 16;
  localparam int unsigned TMO_CNT_W   = 8;

endpackage

// File: rtl/arb_sat_cnt.sv
// 16-bit saturating event counter with enable and synchronous active-low reset.
module arb_sat_cnt
  import cpu_types_pkg::*;
(
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   en,
  output logic [GRANT_CNT_W-1:0] cnt
);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Icache/dcache to single-port RAM arbiter with alternation, timeout and sticky error.
// Optional grant counters enabled by CACHE_ARB_PERF_EN.
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err,
  output logic [15:0] dgrant_cnt,
  output logic [15:0] igrant_cnt
);

  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

  arb_state_t           state, state_n;
  ramstate_t            rs;
  logic                 last_d, last_d_n;
  logic                 err_n;
  logic [TMO_CNT_W-1:0] tcnt, tcnt_n;

  assign rs = ramstate_t'(ramstate);

  always_comb begin
    state_n  = state;
    last_d_n = last_d;
    tcnt_n   = tcnt;
    err_n    = err;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    case (state)
      IDLE: begin
        tcnt_n = '0;
        if ((dREN || dWEN) && !(last_d && iREN)) state_n = DSERV;
        else if (iREN)                            state_n = ISERV;
      end
      DSERV: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        // ACCESS is checked first so a same-cycle deassertion still completes
        if (rs == ACCESS) begin
          dwait    = 1'b0;
          dload    = ramload;
          last_d_n = 1'b1;
          state_n  = IDLE;
        end else if (!(dREN || dWEN)) begin
          state_n = IDLE;
        end else if ((rs == ERROR) || (tcnt == TMO_LAST)) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          tcnt_n = tcnt + 8'd1;
        end
      end
      ISERV: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (rs == ACCESS) begin
          iwait    = 1'b0;
          iload    = ramload;
          last_d_n = 1'b0;
          state_n  = IDLE;
        end else if (!iREN) begin
          state_n = IDLE;
        end else if ((rs == ERROR) || (tcnt == TMO_LAST)) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          tcnt_n = tcnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state  <= IDLE;
      last_d <= 1'b0;
      tcnt   <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      last_d <= last_d_n;
      tcnt   <= tcnt_n;
      err    <= err_n;
    end
  end

`ifdef CACHE_ARB_PERF_EN
  logic d_done, i_done;

  assign d_done = (state == DSERV) && (rs == ACCESS);
  assign i_done = (state == ISERV) && (rs == ACCESS);

  arb_sat_cnt u_dgrant_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .en   (d_done),
    .cnt  (dgrant_cnt)
  );

  arb_sat_cnt u_igrant_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .en   (i_done),
    .cnt  (igrant_cnt)
  );
`else
  assign dgrant_cnt = '0;
  assign igrant_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter; expects grant counters when CACHE_ARB_PERF_EN is defined.
module tb_cache_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic [15:0] dgrant_cnt, igrant_cnt;

  cache_mem_arbiter #(.TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .err(err), .dgrant_cnt(dgrant_cnt), .igrant_cnt(igrant_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        is_d;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] store;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   comp_total = 0;
  int   ram_mode = 0;   // 0: ACCESS on 2nd strobed cycle, 1: stuck BUSY, 2: ERROR
  int   ram_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  task automatic push_exp(input logic is_d, input logic wen, input logic [31:0] a, input logic [31:0] st);
    exp_t e;
    e.is_d = is_d; e.wen = wen; e.addr = a; e.data = model_load(a); e.store = st;
    sb.push_back(e);
  endtask

  // RAM model
  always_comb begin
    ramload = model_load(ramaddr);
    if (!(ramREN || ramWEN))  ramstate = FREE;
    else if (ram_mode == 1)   ramstate = BUSY;
    else if (ram_mode == 2)   ramstate = ERROR;
    else                      ramstate = (ram_cnt == 1) ? ACCESS : BUSY;
  end

  always @(posedge CLK) begin
    if ((ramREN || ramWEN) && (ramstate != ACCESS)) ram_cnt <= ram_cnt + 1;
    else ram_cnt <= 0;
  end

  // Completion monitor
  always @(negedge CLK) begin
    if (iwait) check("iload_zero", iload, 32'h0);
    if (dwait) check("dload_zero", dload, 32'h0);
    if (!iwait || !dwait) begin
      check("one_wait_low", {31'b0, iwait | dwait}, 32'h1);
      if (sb.size() == 0) begin
        check("unexpected_comp", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("comp_port_d", {31'b0, ~dwait}, {31'b0, e.is_d});
        check("comp_addr", ramaddr, e.addr);
        check("comp_wen", {31'b0, ramWEN}, {31'b0, e.wen});
        check("comp_ren", {31'b0, ramREN}, {31'b0, ~e.wen});
        check("comp_store", ramstore, e.store);
        check("comp_load", e.is_d ? dload : iload, e.data);
      end
      comp_total++;
    end
  end

  task automatic wait_comps(input string tag, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK);
      if (comp_total >= target) break;
    end
    check(tag, {31'b0, comp_total >= target}, 32'h1);
    #1;
  endtask

  task automatic idle_inputs();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    ram_mode = 0;
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  logic [15:0] exp_dcnt, exp_icnt;
  int base;

  initial begin
    nRST = 1'b0;
    idle_inputs();
    reset_dut();
    check("rst_iwait", {31'b0, iwait}, 32'h1);
    check("rst_dwait", {31'b0, dwait}, 32'h1);
    check("rst_ramren", {31'b0, ramREN}, 32'h0);
    check("rst_ramwen", {31'b0, ramWEN}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_loads", iload | dload, 32'h0);
    check("rst_cnts", {dgrant_cnt, igrant_cnt}, 32'h0);

    // Single icache read, ACCESS on 2nd service cycle
    base = comp_total;
    iREN = 1'b1; iaddr = 32'h40;
    push_exp(1'b0, 1'b0, 32'h40, 32'h0);
    @(posedge CLK); #1;
    check("i_first_ren", {31'b0, ramREN}, 32'h1);
    check("i_first_addr", ramaddr, 32'h40);
    check("i_first_iwait", {31'b0, iwait}, 32'h1);
    check("i_first_dwait", {31'b0, dwait}, 32'h1);
    wait_comps("wait_i_single", base + 1, 10);
    iREN = 1'b0;
    repeat (3) @(posedge CLK); #1;
    check("i_single_count", comp_total - base, 32'h1);

    // Both pending from reset: D, I, D alternation
    reset_dut();
    base = comp_total;
    iREN = 1'b1; iaddr = 32'h100;
    dWEN = 1'b1; daddr = 32'h80; dstore = 32'h12345678;
    push_exp(1'b1, 1'b1, 32'h80, 32'h12345678);
    push_exp(1'b0, 1'b0, 32'h100, 32'h0);
    push_exp(1'b1, 1'b1, 32'h80, 32'h12345678);
    wait_comps("wait_alt", base + 3, 30);
    idle_inputs();

    // Reset mid-DSERV (counters from the run above are cleared)
    dWEN = 1'b1; daddr = 32'h500; dstore = 32'h0BAD_F00D;
    @(posedge CLK); #1;
    check("midrst_wen_pre", {31'b0, ramWEN}, 32'h1);
    nRST = 1'b0; dWEN = 1'b0;
    @(posedge CLK); #1;
    check("midrst_wen", {31'b0, ramWEN}, 32'h0);
    check("midrst_waits", {30'b0, dwait, iwait}, 32'h3);
    check("midrst_cnts", {dgrant_cnt, igrant_cnt}, 32'h0);
    check("midrst_err", {31'b0, err}, 32'h0);
    nRST = 1'b1;

    // Timeout with RAM stuck BUSY
    reset_dut();
    ram_mode = 1;
    dREN = 1'b1; daddr = 32'h200;
    repeat (4) @(posedge CLK); #1;
    check("tmo_err_early", {31'b0, err}, 32'h0);
    check("tmo_ren_early", {31'b0, ramREN}, 32'h1);
    @(posedge CLK); #1;
    check("tmo_err", {31'b0, err}, 32'h1);
    check("tmo_idle_ren", {31'b0, ramREN}, 32'h0);
    check("tmo_dwait", {31'b0, dwait}, 32'h1);
    dREN = 1'b0;

    // RAM ERROR during ISERV; err is sticky until reset
    reset_dut();
    ram_mode = 2;
    iREN = 1'b1; iaddr = 32'h300;
    @(posedge CLK); #1;
    check("rerr_iwait_svc", {31'b0, iwait}, 32'h1);
    @(posedge CLK); #1;
    check("rerr_err", {31'b0, err}, 32'h1);
    check("rerr_iwait", {31'b0, iwait}, 32'h1);
    iREN = 1'b0; ram_mode = 0;
    repeat (3) @(posedge CLK); #1;
    check("rerr_sticky", {31'b0, err}, 32'h1);
    reset_dut();
    check("rerr_cleared", {31'b0, err}, 32'h0);

    // Grant counters: 3 D then 2 I completions
    base = comp_total;
    dREN = 1'b1; daddr = 32'h300;
    repeat (3) push_exp(1'b1, 1'b0, 32'h300, 32'h0);
    wait_comps("wait_perf_d", base + 3, 30);
    dREN = 1'b0;
    iREN = 1'b1; iaddr = 32'h400;
    repeat (2) push_exp(1'b0, 1'b0, 32'h400, 32'h0);
    wait_comps("wait_perf_i", base + 5, 30);
    iREN = 1'b0;
`ifdef CACHE_ARB_PERF_EN
    exp_dcnt = 16'd3; exp_icnt = 16'd2;
`else
    exp_dcnt = 16'd0; exp_icnt = 16'd0;
`endif
    @(posedge CLK); #1;
    check("dgrant_cnt", {16'b0, dgrant_cnt}, {16'b0, exp_dcnt});
    check("igrant_cnt", {16'b0, igrant_cnt}, {16'b0, exp_icnt});

    // Aborted I grant must leave last_d set by the preceding D completion
    reset_dut();
    base = comp_total;
    dREN = 1'b1; daddr = 32'h600;
    push_exp(1'b1, 1'b0, 32'h600, 32'h0);
    wait_comps("wait_abort_d", base + 1, 10);
    dREN = 1'b0;
    iREN = 1'b1; iaddr = 32'h700;
    @(posedge CLK); @(posedge CLK); #1;
    check("abort_ren_pre", {31'b0, ramREN}, 32'h1);
    iREN = 1'b0;
    #1;
    check("abort_ren_drop", {31'b0, ramREN}, 32'h0);
    @(posedge CLK); #1;
    iREN = 1'b1; dREN = 1'b1;
    push_exp(1'b0, 1'b0, 32'h700, 32'h0);
    push_exp(1'b1, 1'b0, 32'h600, 32'h0);
    wait_comps("wait_abort_both", base + 3, 20);
    idle_inputs();

    repeat (2) @(posedge CLK); #1;
    check("sb_empty", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
